// File: rtl/ram_port_arbiter_pkg.sv
// Shared CPU memory map and arbiter state encodings for the RAM port arbiter slice.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package ram_port_arbiter_pkg;

  // Memory map: RAM sits below the ROM, which is decoded outside the arbiter.
  localparam logic [7:0] CPU_RAM_BASE = 8'h00;
  localparam int         CPU_RAM_SIZE = 64;
  localparam logic [7:0] CPU_ROM_BASE = 8'h40;

  // Arbiter FSM encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  // Identity of the port that most recently took ownership.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // Unsigned range check, one bit wider than the address so base+depth
  // cannot wrap around the top of the 8-bit space.
  function automatic logic in_ram(input logic [7:0] addr, input logic [7:0] base,
                                  input int depth);
    return ({1'b0, addr} >= {1'b0, base}) &&
           ({1'b0, addr} < ({1'b0, base} + 9'(depth)));
  endfunction

endpackage

// File: rtl/ram_port_arbiter_sync_ram_sp.sv
// Single-port synchronous RAM with write enable; contents are never reset.
// Latency: read data appears one cycle after the address is presented.
// Backpressure: none; accepts one access every cycle.
module sync_ram_sp #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write on enable and register the read word every cycle; a read of the
  // address being written returns the old word, which no caller consumes.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port req/gnt arbiter owning the data RAM, round-robin with a burst cap.
// Latency: gnt one cycle after req from idle; read data one cycle after the access.
// Backpressure: non-owner holds req until granted; owner yields after MAX_BURST accesses if the other waits.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter logic [7:0] RAM_BASE  = CPU_RAM_BASE,
  parameter int         RAM_DEPTH = CPU_RAM_SIZE,
  parameter int         MAX_BURST = 4
) (
  input  logic       cpu_clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_gnt,
  output logic       a_rvalid,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic [7:0] b_rdata,
  output logic       addr_err
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(MAX_BURST);

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic          last_owner;
  logic [CW-1:0] burst_cnt;

  logic          sel_a;
  logic          sel_b;
  logic          a_acc;
  logic          b_acc;
  logic          acc;
  logic [7:0]    mux_addr;
  logic          mux_we;
  logic [7:0]    mux_wdata;
  logic          in_range;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic [7:0]    ram_dout;
  logic          rd_oor;
  logic [7:0]    rd_word;
  logic [7:0]    a_rdata_q;
  logic [7:0]    b_rdata_q;
  logic          burst_done;

  // Grants come straight from the state register, so req never reaches gnt combinationally.
  assign sel_a = (state == ST_OWN_A);
  assign sel_b = (state == ST_OWN_B);
  assign a_gnt = sel_a;
  assign b_gnt = sel_b;

  assign a_acc = a_req & sel_a;
  assign b_acc = b_req & sel_b;
  assign acc   = a_acc | b_acc;

  // The owner's request fields drive the RAM; the other port's fields are ignored.
  assign mux_addr  = sel_a ? a_addr  : b_addr;
  assign mux_we    = sel_a ? a_we    : b_we;
  assign mux_wdata = sel_a ? a_wdata : b_wdata;

  assign in_range = in_ram(mux_addr, RAM_BASE, RAM_DEPTH);
  assign ram_idx  = AW'(mux_addr - RAM_BASE);
  // Out-of-range writes are dropped, as is anything coinciding with reset.
  assign ram_we   = acc & mux_we & in_range & ~reset;

  // True when this cycle's access uses up the owner's burst allowance.
  assign burst_done = acc && (({1'b0, burst_cnt} + (CW + 1)'(1)) >= LIMIT);

  // Next-owner selection: round-robin on ties, yield on drop or exhausted burst.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (a_req && b_req) begin
          next_state = (last_owner == OWNER_B) ? ST_OWN_A : ST_OWN_B;
        end else if (a_req) begin
          next_state = ST_OWN_A;
        end else if (b_req) begin
          next_state = ST_OWN_B;
        end
      end
      ST_OWN_A: begin
        if (!a_req) begin
          next_state = b_req ? ST_OWN_B : ST_IDLE;
        end else if (b_req && burst_done) begin
          next_state = ST_OWN_B;
        end
      end
      ST_OWN_B: begin
        if (!b_req) begin
          next_state = a_req ? ST_OWN_A : ST_IDLE;
        end else if (a_req && burst_done) begin
          next_state = ST_OWN_A;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Ownership state, last owner and the per-owner access counter (saturating).
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_owner <= OWNER_B;
      burst_cnt  <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        burst_cnt <= '0;
        if (next_state == ST_OWN_A) begin
          last_owner <= OWNER_A;
        end else if (next_state == ST_OWN_B) begin
          last_owner <= OWNER_B;
        end
      end else if (acc && (burst_cnt < CW'(MAX_BURST))) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  sync_ram_sp #(
    .DEPTH (RAM_DEPTH),
    .WIDTH (8),
    .AW    (AW)
  ) u_ram (
    .clk   (cpu_clk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (mux_wdata),
    .dout  (ram_dout)
  );

  // Out-of-range reads return zero instead of an aliased RAM word.
  assign rd_word  = rd_oor ? 8'h00 : ram_dout;
  assign a_rdata  = a_rvalid ? rd_word : a_rdata_q;
  assign b_rdata  = b_rvalid ? rd_word : b_rdata_q;

  // Read-valid pulses, range-error pulse and the held copies of each port's read data.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      rd_oor    <= 1'b0;
      addr_err  <= 1'b0;
      a_rdata_q <= 8'h00;
      b_rdata_q <= 8'h00;
    end else begin
      a_rvalid  <= a_acc & ~a_we;
      b_rvalid  <= b_acc & ~b_we;
      rd_oor    <= ~in_range;
      addr_err  <= acc & ~in_range;
      a_rdata_q <= a_rdata;
      b_rdata_q <= b_rdata;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: cycle table plus a hand-written reset-mid-access sequence.
// Latency: each table row is one cycle; outputs compared at the falling edge before driving inputs.
// Backpressure: n/a (bench drives req levels directly).
module tb_ram_port_arbiter;

  typedef struct packed {
    logic       rst;
    logic       a_req;
    logic       a_we;
    logic [7:0] a_addr;
    logic [7:0] a_wdata;
    logic       b_req;
    logic       b_we;
    logic [7:0] b_addr;
    logic [7:0] b_wdata;
  } in_t;

  typedef struct packed {
    logic       a_gnt;
    logic       b_gnt;
    logic       a_rvalid;
    logic [7:0] a_rdata;
    logic       b_rvalid;
    logic [7:0] b_rdata;
    logic       addr_err;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int NV = 29;

  logic       cpu_clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, addr_err;
  logic [7:0] a_rdata, b_rdata;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NV];

  always #5 cpu_clk = ~cpu_clk;

  ram_port_arbiter dut (
    .cpu_clk  (cpu_clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .addr_err (addr_err)
  );

  function automatic in_t mi(logic rst, logic ar, logic aw, logic [7:0] aa, logic [7:0] ad,
                             logic br, logic bw, logic [7:0] ba, logic [7:0] bd);
    return {rst, ar, aw, aa, ad, br, bw, ba, bd};
  endfunction

  function automatic out_t mo(logic ag, logic bg, logic av, logic [7:0] ad,
                              logic bv, logic [7:0] bd, logic err);
    return {ag, bg, av, ad, bv, bd, err};
  endfunction

  function automatic out_t sample();
    return {a_gnt, b_gnt, a_rvalid, a_rdata, b_rvalid, b_rdata, addr_err};
  endfunction

  task automatic drive(input in_t v);
    reset   = v.rst;
    a_req   = v.a_req;
    a_we    = v.a_we;
    a_addr  = v.a_addr;
    a_wdata = v.a_wdata;
    b_req   = v.b_req;
    b_we    = v.b_we;
    b_addr  = v.b_addr;
    b_wdata = v.b_wdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Grants must be mutually exclusive in every cycle.
  always @(negedge cpu_clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (a_gnt && b_gnt) begin
        errors++;
        $display("FAIL gnt_exclusive: a_gnt=%b b_gnt=%b required not both", a_gnt, b_gnt);
      end
    end
  end

  initial begin
    // rst, a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata  |  a_gnt, b_gnt, a_rv, a_rd, b_rv, b_rd, err
    // A writes 0x03=0x0F, then reads it back, then drops.
    vecs[0]  = '{mi(0,1,1,8'h03,8'h0F,0,0,8'h00,8'h00), mo(0,0,0,8'h00,0,8'h00,0)};
    vecs[1]  = '{mi(0,1,1,8'h03,8'h0F,0,0,8'h00,8'h00), mo(1,0,0,8'h00,0,8'h00,0)};
    vecs[2]  = '{mi(0,1,0,8'h03,8'h00,0,0,8'h00,8'h00), mo(1,0,0,8'h00,0,8'h00,0)};
    vecs[3]  = '{mi(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), mo(1,0,1,8'h0F,0,8'h00,0)};
    // Reset clears held read data but not the RAM.
    vecs[4]  = '{mi(1,0,0,8'h00,8'h00,0,0,8'h00,8'h00), mo(0,0,0,8'h0F,0,8'h00,0)};
    // Tie from IDLE after reset: A first, 4 accesses each, B writes 0x10=0xB1.
    vecs[5]  = '{mi(0,1,0,8'h03,8'h00,1,1,8'h10,8'hB1), mo(0,0,0,8'h00,0,8'h00,0)};
    vecs[6]  = '{mi(0,1,0,8'h03,8'h00,1,1,8'h10,8'hB1), mo(1,0,0,8'h00,0,8'h00,0)};
    vecs[7]  = '{mi(0,1,0,8'h03,8'h00,1,1,8'h10,8'hB1), mo(1,0,1,8'h0F,0,8'h00,0)};
    vecs[8]  = '{mi(0,1,0,8'h03,8'h00,1,1,8'h10,8'hB1), mo(1,0,1,8'h0F,0,8'h00,0)};
    vecs[9]  = '{mi(0,1,0,8'h03,8'h00,1,1,8'h10,8'hB1), mo(1,0,1,8'h0F,0,8'h00,0)};
    vecs[10] = '{mi(0,1,0,8'h03,8'h00,1,1,8'h10,8'hB1), mo(0,1,1,8'h0F,0,8'h00,0)};
    vecs[11] = '{mi(0,1,0,8'h03,8'h00,1,1,8'h10,8'hB1), mo(0,1,0,8'h0F,0,8'h00,0)};
    vecs[12] = '{mi(0,1,0,8'h03,8'h00,1,1,8'h10,8'hB1), mo(0,1,0,8'h0F,0,8'h00,0)};
    vecs[13] = '{mi(0,1,0,8'h03,8'h00,1,1,8'h10,8'hB1), mo(0,1,0,8'h0F,0,8'h00,0)};
    // Back to A; it reads 0x03 then B's word at 0x10, then hands over.
    vecs[14] = '{mi(0,1,0,8'h03,8'h00,0,0,8'h00,8'h00), mo(1,0,0,8'h0F,0,8'h00,0)};
    vecs[15] = '{mi(0,1,0,8'h10,8'h00,0,0,8'h00,8'h00), mo(1,0,1,8'h0F,0,8'h00,0)};
    vecs[16] = '{mi(0,0,0,8'h00,8'h00,1,1,8'h01,8'h11), mo(1,0,1,8'hB1,0,8'h00,0)};
    // B alone: write 0x01, out-of-range read and write of 0x41, then held reads.
    vecs[17] = '{mi(0,0,0,8'h00,8'h00,1,1,8'h01,8'h11), mo(0,1,0,8'hB1,0,8'h00,0)};
    vecs[18] = '{mi(0,0,0,8'h00,8'h00,1,0,8'h41,8'h00), mo(0,1,0,8'hB1,0,8'h00,0)};
    vecs[19] = '{mi(0,0,0,8'h00,8'h00,1,1,8'h41,8'h55), mo(0,1,0,8'hB1,1,8'h00,1)};
    vecs[20] = '{mi(0,0,0,8'h00,8'h00,1,0,8'h01,8'h00), mo(0,1,0,8'hB1,0,8'h00,1)};
    for (int k = 21; k <= 26; k++) begin
      vecs[k] = '{mi(0,0,0,8'h00,8'h00,1,0,8'h01,8'h00), mo(0,1,0,8'hB1,1,8'h11,0)};
    end
    vecs[27] = '{mi(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), mo(0,1,0,8'hB1,1,8'h11,0)};
    vecs[28] = '{mi(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), mo(0,0,0,8'hB1,0,8'h11,0)};

    drive(mi(1,0,0,8'h00,8'h00,0,0,8'h00,8'h00));
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    chk("reset_state", 32'(sample()), 32'(mo(0,0,0,8'h00,0,8'h00,0)));
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(negedge cpu_clk);
      chk($sformatf("vec%0d", k), 32'(sample()), 32'(vecs[k].o));
      drive(vecs[k].i);
    end

    // Reset asserted while A owns with a read pending and a write presented.
    @(negedge cpu_clk);
    drive(mi(0,1,1,8'h20,8'hAA,0,0,8'h00,8'h00));
    @(negedge cpu_clk);
    chk("rst_seq_gnt", 32'(a_gnt), 32'd1);
    @(negedge cpu_clk);
    a_we = 1'b0;
    @(negedge cpu_clk);
    chk("rst_seq_rd_before", 32'({a_rvalid, a_rdata}), 32'({1'b1, 8'hAA}));
    a_we    = 1'b1;
    a_wdata = 8'hCC;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_seq_drop", 32'(sample()), 32'(mo(0,0,0,8'h00,0,8'h00,0)));
    @(negedge cpu_clk);
    drive(mi(0,1,0,8'h20,8'h00,1,0,8'h20,8'h00));
    @(negedge cpu_clk);
    chk("rst_seq_tie_a", 32'({a_gnt, b_gnt}), 32'(2'b10));
    @(negedge cpu_clk);
    chk("rst_seq_byte_kept", 32'({a_rvalid, a_rdata}), 32'({1'b1, 8'hAA}));
    drive(mi(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00));
    @(negedge cpu_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
